// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Main control FSM for a multicycle RV32 subset datapath. Sequences each
//   instruction through fetch, decode and a class-specific execute path, and
//   drives the datapath mux selects, write enables and memory strobes for the
//   current state.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   op_i            : opcode field [6:0] of the instruction register
//   mem_ready_i     : memory completed the current access this cycle
//   mem_read_o      : memory read strobe (fetch or load)
//   mem_write_o     : memory write strobe (store)
//   i_or_d_o        : memory address select, 0 = PC, 1 = ALU out register
//   ir_write_o      : load instruction register and old-PC register
//   pc_write_o      : unconditional PC update
//   branch_o        : conditional PC update (gated by ALU zero in datapath)
//   reg_write_o     : register file write enable
//   alu_src_a_o     : ALU A select, 0 = PC, 1 = old PC, 2 = rs1, 3 = zero
//   alu_src_b_o     : ALU B select, 0 = rs2, 1 = immediate, 2 = constant 4
//   alu_op_o        : 0 = add, 1 = subtract, 2 = decode funct fields
//   result_src_o    : 0 = ALU out register, 1 = memory data, 2 = ALU result
//   state_o         : current state code
//   illegal_o       : sticky unsupported-opcode flag
//   instret_o       : retired-instruction count (wraps)
module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op_i,
    input  logic        mem_ready_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        i_or_d_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        branch_o,
    output logic        reg_write_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  result_src_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP)
                illegal_q <= 1'b1;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'd0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = 2'd0;
        result_src_o = 2'd0;

        case (state_q)
            FETCH: begin
                mem_read_o = 1'b1;
                // PC + 4 is computed and written in the same cycle the
                // instruction word arrives.
                if (mem_ready_i) begin
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    alu_src_b_o  = 2'd2;
                    result_src_o = 2'd2;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                state_d     = (op_i == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i)
                    state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'd1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a_o = 2'd2;
                alu_op_o    = 2'd2;
                state_d     = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                alu_op_o    = 2'd2;
                state_d     = ALU_WB;
            end
            ALU_WB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 2'd2;
                alu_op_o    = 2'd1;
                branch_o    = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                // old PC + 4 becomes the link value; target already in ALU out
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd2;
                pc_write_o  = 1'b1;
                state_d     = ALU_WB;
            end
            JALR: begin
                alu_src_a_o  = 2'd2;
                alu_src_b_o  = 2'd1;
                result_src_o = 2'd2;
                pc_write_o   = 1'b1;
                state_d      = ALU_WB;
            end
            LUI: begin
                alu_src_a_o = 2'd3;
                alu_src_b_o = 2'd1;
                state_d     = ALU_WB;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op_i = 7'b0110011;
    logic        mem_ready_i = 1'b1;
    logic        mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o;
    logic        branch_o, reg_write_o, illegal_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [3:0]  state_o;
    logic [31:0] instret_o;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .op_i         (op_i),
        .mem_ready_i  (mem_ready_i),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .i_or_d_o     (i_or_d_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .branch_o     (branch_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .result_src_o (result_src_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o),
        .instret_o    (instret_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        chk;
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        ill;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic c, input logic rst, input logic [6:0] op,
                               input logic rdy, input logic [3:0] st, input logic mr,
                               input logic mw, input logic rw, input logic ill,
                               input logic [31:0] ir);
        vec_t r;
        r.chk = c; r.rst = rst; r.op = op; r.rdy = rdy; r.st = st;
        r.mr = mr; r.mw = mw; r.rw = rw; r.ill = ill; r.ir = ir;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Expected control word {mem_read, mem_write, i_or_d, ir_write, pc_write,
    // branch, reg_write, src_a, src_b, alu_op, result_src} for each state.
    function automatic logic [14:0] ctrl_exp(input int st, input logic rdy);
        case (st)
            0:  return rdy ? {7'b1001100, 2'd0, 2'd2, 2'd0, 2'd2}
                           : {7'b1000000, 8'd0};
            1:  return {7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0};
            2:  return {7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0};
            3:  return {7'b1010000, 8'd0};
            4:  return {7'b0000001, 2'd0, 2'd0, 2'd0, 2'd1};
            5:  return {7'b0110000, 8'd0};
            6:  return {7'b0000000, 2'd2, 2'd0, 2'd2, 2'd0};
            7:  return {7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0};
            8:  return {7'b0000001, 8'd0};
            9:  return {7'b0000010, 2'd2, 2'd0, 2'd1, 2'd0};
            10: return {7'b0000100, 2'd1, 2'd2, 2'd0, 2'd0};
            11: return {7'b0000100, 2'd2, 2'd1, 2'd0, 2'd2};
            12: return {7'b0000000, 2'd3, 2'd1, 2'd0, 2'd0};
            default: return '0;
        endcase
    endfunction

    int plan[$];

    // Full state path of one instruction, from fetch to its final state.
    function automatic void plan_for(input logic [6:0] op);
        plan = {};
        plan.push_back(0);
        plan.push_back(1);
        case (op)
            7'b0000011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
            7'b0100011: begin plan.push_back(2); plan.push_back(5); end
            7'b0110011: begin plan.push_back(6); plan.push_back(8); end
            7'b0010011: begin plan.push_back(7); plan.push_back(8); end
            7'b1100011: plan.push_back(9);
            7'b1101111: begin plan.push_back(10); plan.push_back(8); end
            7'b1100111: begin plan.push_back(11); plan.push_back(8); end
            7'b0110111: begin plan.push_back(12); plan.push_back(8); end
            default:    plan.push_back(13);
        endcase
    endfunction

    function automatic logic [6:0] pick_op();
        logic [6:0] legal [8];
        int r;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        r = $urandom_range(0, 39);
        if (r == 0)
            return ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000;
        return legal[r % 8];
    endfunction

    task automatic random_phase(input int cycles);
        int          m_instret;
        bit          m_ill;
        logic [6:0]  cur_op;
        logic        rdy, do_rst;
        int          st;
        bit          wait_here;
        logic [14:0] act_ctrl;

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_instret = 0;
        m_ill     = 1'b0;
        cur_op    = pick_op();
        op_i      = cur_op;
        plan_for(cur_op);

        for (int c = 0; c < cycles; c++) begin
            rdy         = ($urandom_range(0, 3) != 0);
            do_rst      = ($urandom_range(0, 63) == 0);
            mem_ready_i = rdy;
            reset       = do_rst;
            #1;
            st = plan[0];
            act_ctrl = {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
                        branch_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                        result_src_o};
            chk("rnd_state", {28'd0, state_o}, st);
            chk("rnd_ctrl", {17'd0, act_ctrl}, {17'd0, ctrl_exp(st, rdy)});
            chk("rnd_illegal", {31'd0, illegal_o}, {31'd0, m_ill});
            chk("rnd_instret", instret_o, m_instret);

            if (do_rst) begin
                m_instret = 0;
                m_ill     = 1'b0;
                cur_op    = pick_op();
                plan_for(cur_op);
            end else begin
                wait_here = (st == 13) || (((st == 0) || (st == 3) || (st == 5)) && !rdy);
                if (!wait_here) begin
                    void'(plan.pop_front());
                    if (plan.size() == 0) begin
                        m_instret++;
                        cur_op = pick_op();
                        plan_for(cur_op);
                    end else if (plan[0] == 13) begin
                        m_ill = 1'b1;
                    end
                end
            end
            op_i = cur_op;
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        // R-type
        vecs.push_back(v(0, 1, 7'h33, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h33, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h33, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h33, 1, 6, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h33, 1, 8, 0, 0, 1, 0, 0));
        // load with three stall cycles
        vecs.push_back(v(1, 0, 7'h03, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 7'h03, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 7'h03, 1, 2, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 0, 7'h03, 0, 3, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 7'h03, 1, 3, 1, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 7'h03, 1, 4, 0, 0, 1, 0, 1));
        // store
        vecs.push_back(v(1, 0, 7'h23, 1, 0, 1, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 7'h23, 1, 1, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 7'h23, 1, 2, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 7'h23, 1, 5, 0, 1, 0, 0, 2));
        // branch
        vecs.push_back(v(1, 0, 7'h63, 1, 0, 1, 0, 0, 0, 3));
        vecs.push_back(v(1, 0, 7'h63, 1, 1, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 0, 7'h63, 1, 9, 0, 0, 0, 0, 3));
        // illegal opcode, trap held, then reset
        vecs.push_back(v(1, 0, 7'h7F, 1, 0, 1, 0, 0, 0, 4));
        vecs.push_back(v(1, 0, 7'h7F, 1, 1, 0, 0, 0, 0, 4));
        for (int i = 0; i < 11; i++)
            vecs.push_back(v(1, 0, 7'h7F, i[0], 13, 0, 0, 0, 1, 4));
        vecs.push_back(v(1, 1, 7'h7F, 1, 13, 0, 0, 0, 1, 4));
        // reset in the middle of a stalled load read
        vecs.push_back(v(1, 0, 7'h03, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h03, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h03, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h03, 0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 7'h03, 0, 3, 1, 0, 0, 0, 0));
        // fetch stall, then proceed
        vecs.push_back(v(1, 0, 7'h03, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h03, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 7'h03, 1, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            op_i        = vecs[i].op;
            mem_ready_i = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                chk("vec_state", {28'd0, state_o}, {28'd0, vecs[i].st});
                chk("vec_mem_read", {31'd0, mem_read_o}, {31'd0, vecs[i].mr});
                chk("vec_mem_write", {31'd0, mem_write_o}, {31'd0, vecs[i].mw});
                chk("vec_reg_write", {31'd0, reg_write_o}, {31'd0, vecs[i].rw});
                chk("vec_illegal", {31'd0, illegal_o}, {31'd0, vecs[i].ill});
                chk("vec_instret", instret_o, vecs[i].ir);
            end
        end

        // counter wrap: preload all-ones, retire one branch
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        op_i        = 7'b1100011;
        mem_ready_i = 1'b1;
        dut.instret_q = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", instret_o, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_branch_state", {28'd0, state_o}, 32'd9);
        chk("wrap_mid", instret_o, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("wrap_state", {28'd0, state_o}, 32'd0);
        chk("wrap_post", instret_o, 32'h0000_0000);

        random_phase(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
